// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the IMEM boot loader.
package imem_loader_pkg;

  localparam int LEN_W          = 16;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHK,
    DONE,
    ERR
  } loader_state_e;

  // A new load may only begin from a resting state.
  function automatic logic can_start(loader_state_e s);
    return (s == IDLE) || (s == DONE) || (s == ERR);
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Host byte stream plus IMEM write port; the loader is the slave side.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 8
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader_word_assembler.sv
// Packs big-endian bytes into 32-bit words; word_valid marks the byte completing a word.
module loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  // Only the three earlier bytes are stored; the fourth is taken straight from the input.
  logic [23:0] shreg_q, shreg_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (clear) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (shift_en) begin
      shreg_d = {shreg_q[15:0], byte_in};
      cnt_d   = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign word_valid = shift_en && (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word       = {shreg_q, byte_in};

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed byte image into IMEM while holding the CPU.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  imem_boot_loader_if.slave   bus,
  output logic                cpu_hold,
  output logic                done,
  output logic                err
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

  loader_state_e     state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] imem_waddr_q, imem_waddr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              byte_ready_q, byte_ready_d;
  logic              imem_we_q, imem_we_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic             transfer;
  logic             start_ok;
  logic             word_valid;
  logic [31:0]      word;
  logic [LEN_W-1:0] len_new;
  logic             last_word;

  assign transfer  = bus.byte_valid & byte_ready_q;
  assign start_ok  = start & can_start(state_q);
  assign len_new   = {len_q[LEN_W-1:8], bus.byte_data};
  assign last_word = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));

  loader_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .shift_en   (transfer && (state_q == DATA)),
    .byte_in    (bus.byte_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    imem_waddr_d = imem_waddr_q;
    imem_wdata_d = imem_wdata_q;
    byte_ready_d = byte_ready_q;
    imem_we_d    = 1'b0;
    cpu_hold_d   = cpu_hold_q;
    done_d       = done_q;
    err_d        = err_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    if (start_ok) begin
      state_d      = LEN_HI;
      byte_ready_d = 1'b1;
      cpu_hold_d   = 1'b1;
      done_d       = 1'b0;
      err_d        = 1'b0;
      idx_d        = '0;
`ifdef LOADER_CHECKSUM_EN
      csum_d       = '0;
`endif
    end else begin
      case (state_q)
        LEN_HI: if (transfer) begin
          len_d[LEN_W-1:8] = bus.byte_data;
          state_d          = LEN_LO;
        end
        LEN_LO: if (transfer) begin
          len_d = len_new;
          if (len_new == '0) begin
            state_d      = DONE;
            byte_ready_d = 1'b0;
            done_d       = 1'b1;
            cpu_hold_d   = 1'b0;
          end else if (len_new > MAX_LEN) begin
            state_d      = ERR;
            byte_ready_d = 1'b0;
            err_d        = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
        DATA: begin
`ifdef LOADER_CHECKSUM_EN
          if (transfer) csum_d = csum_q ^ bus.byte_data;
`endif
          // Stall the stream for the write cycle, then resume or finish.
          if (word_valid) begin
            imem_we_d    = 1'b1;
            imem_waddr_d = idx_q;
            imem_wdata_d = word;
            byte_ready_d = 1'b0;
          end else if (imem_we_q) begin
            if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
              state_d      = CHK;
              byte_ready_d = 1'b1;
`else
              state_d      = DONE;
              done_d       = 1'b1;
              cpu_hold_d   = 1'b0;
`endif
            end else begin
              idx_d        = idx_q + 1'b1;
              byte_ready_d = 1'b1;
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHK: if (transfer) begin
          byte_ready_d = 1'b0;
          if (bus.byte_data == csum_q) begin
            state_d    = DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      imem_waddr_q <= '0;
      imem_wdata_q <= '0;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      imem_waddr_q <= imem_waddr_d;
      imem_wdata_q <= imem_wdata_d;
      byte_ready_q <= byte_ready_d;
      imem_we_q    <= imem_we_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      err_q        <= err_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_waddr = imem_waddr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign cpu_hold       = cpu_hold_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Table-driven plus randomized bench for imem_boot_loader; expected writes come from the image bytes.
module tb_imem_boot_loader;

  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 256;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic cpu_hold, done, err;

  imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]        data_b [0:1023];
  logic [ADDR_W-1:0] got_addr [$];
  logic [31:0]       got_data [$];

  // Write and done-edge observer, sampled away from the active edge.
  int   cycle = 0;
  int   first_we_cycle = -1;
  int   last_we_cycle = -1;
  int   done_rise_cycle = -1;
  int   overlap_cnt = 0;
  logic hold_at_rise = 1'b1;
  logic hold_before_rise = 1'b0;
  logic prev_done = 1'b0;
  logic prev_hold = 1'b1;

  always @(negedge clk) begin
    cycle++;
    if (bus.imem_we) begin
      if (got_data.size() == 0) first_we_cycle = cycle;
      got_addr.push_back(bus.imem_waddr);
      got_data.push_back(bus.imem_wdata);
      last_we_cycle = cycle;
      if (bus.byte_ready) overlap_cnt++;
    end
    if (done && !prev_done) begin
      done_rise_cycle  = cycle;
      hold_at_rise     = cpu_hold;
      hold_before_rise = prev_hold;
    end
    prev_done = done;
    prev_hold = cpu_hold;
  end

  typedef struct {
    string       name;
    logic [15:0] len;
    bit          gaps;
    bit          exp_done;
    bit          exp_err;
    int          exp_writes;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checkOutput(name, {31'b0, actual}, {31'b0, expected});
  endtask

  function automatic logic [31:0] model_word(input int i);
    return {data_b[4*i], data_b[4*i+1], data_b[4*i+2], data_b[4*i+3]};
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard;
    if (gaps) begin
      while ($urandom_range(2) == 0) begin
        bus.byte_valid = 1'b0;
        @(negedge clk);
      end
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    guard = 0;
    while (!bus.byte_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) begin
      checkBit("byte_ready_timeout", 1'b0, 1'b1);
      bus.byte_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] len, input bit gaps, input bit bad_csum);
    logic [7:0] x;
    got_addr.delete();
    got_data.delete();
    first_we_cycle  = -1;
    last_we_cycle   = -1;
    done_rise_cycle = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkBit("start_clears_done", done, 1'b0);
    checkBit("start_clears_err", err, 1'b0);
    checkBit("start_holds_cpu", cpu_hold, 1'b1);
    checkBit("start_ready", bus.byte_ready, 1'b1);
    send_byte(len[15:8], gaps);
    send_byte(len[7:0], gaps);
    x = 8'h00;
    if (len != 16'd0 && int'(len) <= MAX_WORDS) begin
      for (int i = 0; i < 4 * int'(len); i++) begin
        send_byte(data_b[i], gaps);
        x ^= data_b[i];
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(x ^ {7'b0, bad_csum}, gaps);
`else
      if (bad_csum) $display("[TB] checksum byte not compiled in, x=0x%0h", x);
`endif
    end
    for (int i = 0; i < 40; i++) begin
      if (done || err) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic verify(input string name, input bit exp_done, input bit exp_err, input int exp_n);
    checkBit({name, "_done"}, done, exp_done);
    checkBit({name, "_err"}, err, exp_err);
    checkBit({name, "_cpu_hold"}, cpu_hold, !exp_done);
    checkBit({name, "_ready_idle"}, bus.byte_ready, 1'b0);
    checkOutput({name, "_nwrites"}, 32'(got_data.size()), 32'(exp_n));
    if (got_data.size() == exp_n) begin
      for (int i = 0; i < exp_n; i++) begin
        checkOutput({name, "_waddr"}, 32'(got_addr[i]), 32'(i));
        checkOutput({name, "_wdata"}, got_data[i], model_word(i));
      end
    end
    if (exp_done) begin
      checkBit({name, "_hold_falls_with_done"}, hold_at_rise, 1'b0);
      checkBit({name, "_hold_before_done"}, hold_before_rise, 1'b1);
`ifndef LOADER_CHECKSUM_EN
      if (exp_n > 0)
        checkOutput({name, "_done_after_last_we"}, 32'(done_rise_cycle), 32'(last_we_cycle + 1));
`endif
    end
  endtask

  vec_t vecs [$];
  int   n_before;

  initial begin
    rst            = 1'b1;
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (2) @(negedge clk);
    checkBit("rst_byte_ready", bus.byte_ready, 1'b0);
    checkBit("rst_imem_we", bus.imem_we, 1'b0);
    checkOutput("rst_waddr", 32'(bus.imem_waddr), 32'd0);
    checkOutput("rst_wdata", bus.imem_wdata, 32'd0);
    checkBit("rst_cpu_hold", cpu_hold, 1'b1);
    checkBit("rst_done", done, 1'b0);
    checkBit("rst_err", err, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Two-word reference image, byte_valid held high.
    data_b[0] = 8'h20; data_b[1] = 8'h08; data_b[2] = 8'h00; data_b[3] = 8'h05;
    data_b[4] = 8'h8C; data_b[5] = 8'h09; data_b[6] = 8'h00; data_b[7] = 8'h04;
    applyStimulus(16'd2, 1'b0, 1'b0);
    verify("two_word", 1'b1, 1'b0, 2);
    if (got_data.size() == 2) begin
      checkOutput("two_word_w0", got_data[0], 32'h2008_0005);
      checkOutput("two_word_w1", got_data[1], 32'h8C09_0004);
      checkOutput("peak_rate", 32'(last_we_cycle - first_we_cycle), 32'd5);
    end

    for (int i = 0; i < 1024; i++) data_b[i] = 8'($urandom);

    vecs.push_back('{"len_zero",   16'd0,   1'b0, 1'b1, 1'b0, 0});
    vecs.push_back('{"len_257",    16'd257, 1'b0, 1'b0, 1'b1, 0});
    vecs.push_back('{"w16_nogap",  16'd16,  1'b0, 1'b1, 1'b0, 16});
    vecs.push_back('{"w16_gaps",   16'd16,  1'b1, 1'b1, 1'b0, 16});
    vecs.push_back('{"w1_gaps",    16'd1,   1'b1, 1'b1, 1'b0, 1});
    vecs.push_back('{"w256_max",   16'd256, 1'b0, 1'b1, 1'b0, 256});
    vecs.push_back('{"len_ffff",   16'hFFFF, 1'b1, 1'b0, 1'b1, 0});
    vecs.push_back('{"w3_gaps",    16'd3,   1'b1, 1'b1, 1'b0, 3});
    foreach (vecs[v]) begin
      applyStimulus(vecs[v].len, vecs[v].gaps, 1'b0);
      verify(vecs[v].name, vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_writes);
    end

    // Reset after the sixth data byte of a four-word load.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    got_data.delete();
    got_addr.delete();
    for (int i = 0; i < 6; i++) send_byte(data_b[i], 1'b0);
    checkOutput("pre_reset_writes", 32'(got_data.size()), 32'd1);
    bus.byte_valid = 1'b1;
    rst = 1'b1;
    #1;
    checkBit("midrst_byte_ready", bus.byte_ready, 1'b0);
    checkBit("midrst_imem_we", bus.imem_we, 1'b0);
    checkOutput("midrst_waddr", 32'(bus.imem_waddr), 32'd0);
    checkOutput("midrst_wdata", bus.imem_wdata, 32'd0);
    checkBit("midrst_cpu_hold", cpu_hold, 1'b1);
    checkBit("midrst_done", done, 1'b0);
    checkBit("midrst_err", err, 1'b0);
    n_before = got_data.size();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("post_reset_no_writes", 32'(got_data.size()), 32'(n_before));
    checkBit("post_reset_ready", bus.byte_ready, 1'b0);
    checkBit("post_reset_hold", cpu_hold, 1'b1);
    bus.byte_valid = 1'b0;
    @(negedge clk);

    applyStimulus(16'd2, 1'b1, 1'b0);
    verify("after_reset", 1'b1, 1'b0, 2);

`ifdef LOADER_CHECKSUM_EN
    data_b[0] = 8'h12; data_b[1] = 8'h34; data_b[2] = 8'h56; data_b[3] = 8'h78;
    applyStimulus(16'd1, 1'b0, 1'b0);
    verify("csum_good", 1'b1, 1'b0, 1);
    applyStimulus(16'd1, 1'b0, 1'b1);
    verify("csum_bad", 1'b0, 1'b1, 1);
`endif

    checkOutput("we_ready_overlap", 32'(overlap_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
